fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares one synchronous FIFO write port among `NUM_REQ` producers. Each producer offers data with a valid/ready handshake. The arbiter grants one producer at a time for a burst of up to `MAX_BURST` beats, then drives the FIFO's `WR`/`DATA_WR` and honours its `FULL` flag. It sits directly in front of the FIFO's write side; the read side is untouched.

---
 rtl/fifo_wr_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_arbiter
//  Description : Round-robin arbiter sharing one synchronous FIFO write port
//                among NUM_REQ valid/ready producers. One producer holds the
//                grant for a burst of up to MAX_BURST beats; the FIFO FULL
//                flag stalls the burst without releasing it.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK           in   1                 clock, rising edge
//    RESETN        in   1                 asynchronous active-low reset
//    REQ_VALID     in   NUM_REQ           producer i offers a beat
//    REQ_DATA      in   NUM_REQ*length    producer i data at [i*length +: length]
//    REQ_LAST      in   NUM_REQ           producer i beat ends its packet
//    REQ_READY     out  NUM_REQ           producer i beat accepted (with valid)
//    FIFO_FULL     in   1                 FIFO full flag
//    FIFO_WR       out  1                 FIFO write strobe
//    FIFO_DATA_WR  out  length            FIFO write data
//    GRANT_VALID   out  1                 a producer holds the grant
//    GRANT_ID      out  ID_W              index of granted producer
//    BEAT_CNT      out  8                 beats accepted in current grant
// ============================================================================
module fifo_wr_arbiter #(
  parameter int length    = 16,
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2,
  parameter int MAX_BURST = 4
) (
  input  logic                      CLK,
  input  logic                      RESETN,
  input  logic [NUM_REQ-1:0]        REQ_VALID,
  input  logic [NUM_REQ*length-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]        REQ_LAST,
  output logic [NUM_REQ-1:0]        REQ_READY,
  input  logic                      FIFO_FULL,
  output logic                      FIFO_WR,
  output logic [length-1:0]         FIFO_DATA_WR,
  output logic                      GRANT_VALID,
  output logic [ID_W-1:0]           GRANT_ID,
  output logic [7:0]                BEAT_CNT
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [0:0]      c_IDLE      = 1'b0;
  localparam logic [0:0]      c_GRANT     = 1'b1;
  localparam logic [7:0]      c_MAX_BURST = 8'(MAX_BURST);
  localparam logic [ID_W:0]   c_NUM_REQ   = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] c_LAST_RST  = ID_W'(NUM_REQ - 1);

  // --------------------------------------------------------------------------
  // State and next-state
  // --------------------------------------------------------------------------
  logic [0:0]      state_q,    state_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic [ID_W-1:0] last_id_q,  last_id_d;
  logic [7:0]      beat_cnt_q, beat_cnt_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic              w_sel_valid;   // REQ_VALID of the granted producer
  logic              w_sel_last;    // REQ_LAST of the granted producer
  logic [length-1:0] w_sel_data;    // REQ_DATA slice of the granted producer
  logic              w_accept;      // a beat is written this cycle
  logic              w_any_valid;
  logic [ID_W-1:0]   w_pick;        // round-robin winner
  logic              w_found;
  logic [ID_W:0]     w_rr_sum;      // one extra bit so last_id+k cannot overflow

  // Mux the granted producer's signals. Indexed by registered grant_id only,
  // so the data path width does not depend on the arbitration search.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == ID_W'(i)) begin
        w_sel_valid = REQ_VALID[i];
        w_sel_last  = REQ_LAST[i];
        w_sel_data  = REQ_DATA[i*length +: length];
      end
    end
  end

  assign w_any_valid = |REQ_VALID;

  // Write strobe never depends on anything but registered state, the granted
  // valid bit and FULL; the FIFO is therefore never written while full.
  assign w_accept = (state_q == c_GRANT) && w_sel_valid && !FIFO_FULL;

  // Round-robin search: offsets 1..NUM_REQ from last_id, wrapping modulo
  // NUM_REQ. Offset NUM_REQ revisits last_id itself, so a lone requester can
  // win again right after its own release.
  always_comb begin
    w_pick   = '0;
    w_found  = 1'b0;
    w_rr_sum = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_rr_sum = {1'b0, last_id_q} + (ID_W+1)'(k);
      if (w_rr_sum >= c_NUM_REQ) begin
        w_rr_sum = w_rr_sum - c_NUM_REQ;
      end
      if (!w_found && REQ_VALID[w_rr_sum[ID_W-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_rr_sum[ID_W-1:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q    <= c_IDLE;
      grant_id_q <= '0;
      last_id_q  <= c_LAST_RST;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      last_id_q  <= last_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    last_id_d  = last_id_q;
    beat_cnt_d = beat_cnt_q;

    case (state_q)
      c_IDLE: begin
        if (w_any_valid) begin
          state_d    = c_GRANT;
          grant_id_d = w_pick;
          beat_cnt_d = '0;
        end
      end

      c_GRANT: begin
        if (w_accept) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          // End of packet or burst budget exhausted.
          if (w_sel_last || (beat_cnt_q + 8'd1 == c_MAX_BURST)) begin
            state_d   = c_IDLE;
            last_id_d = grant_id_q;
          end
        end else if (!w_sel_valid && !FIFO_FULL) begin
          // Granted producer has nothing to offer while the FIFO could take
          // it: give the port up. A stall caused by FULL never releases.
          state_d   = c_IDLE;
          last_id_d = grant_id_q;
        end
      end

      default: begin
        state_d = c_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    REQ_READY    = '0;
    FIFO_WR      = 1'b0;
    FIFO_DATA_WR = '0;
    GRANT_VALID  = (state_q == c_GRANT);
    GRANT_ID     = grant_id_q;
    BEAT_CNT     = beat_cnt_q;

    if (state_q == c_GRANT) begin
      // Ready is a function of FULL only; valid never feeds back into ready.
      for (int i = 0; i < NUM_REQ; i++) begin
        REQ_READY[i] = (grant_id_q == ID_W'(i)) && !FIFO_FULL;
      end
      FIFO_WR = w_accept;
      if (w_accept) begin
        FIFO_DATA_WR = w_sel_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_wr_arbiter
//  Description : Directed self-checking bench for fifo_wr_arbiter
//                (length=16, NUM_REQ=4, ID_W=2, MAX_BURST=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

  localparam int c_LEN = 16;
  localparam int c_NR  = 4;
  localparam int c_IDW = 2;
  localparam int c_MB  = 4;

  logic                  CLK = 1'b0;
  logic                  RESETN;
  logic [c_NR-1:0]       REQ_VALID;
  logic [c_NR*c_LEN-1:0] REQ_DATA;
  logic [c_NR-1:0]       REQ_LAST;
  logic [c_NR-1:0]       REQ_READY;
  logic                  FIFO_FULL;
  logic                  FIFO_WR;
  logic [c_LEN-1:0]      FIFO_DATA_WR;
  logic                  GRANT_VALID;
  logic [c_IDW-1:0]      GRANT_ID;
  logic [7:0]            BEAT_CNT;

  int n_checks = 0;
  int n_errors = 0;

  fifo_wr_arbiter #(
    .length    (c_LEN),
    .NUM_REQ   (c_NR),
    .ID_W      (c_IDW),
    .MAX_BURST (c_MB)
  ) u_dut (
    .CLK          (CLK),
    .RESETN       (RESETN),
    .REQ_VALID    (REQ_VALID),
    .REQ_DATA     (REQ_DATA),
    .REQ_LAST     (REQ_LAST),
    .REQ_READY    (REQ_READY),
    .FIFO_FULL    (FIFO_FULL),
    .FIFO_WR      (FIFO_WR),
    .FIFO_DATA_WR (FIFO_DATA_WR),
    .GRANT_VALID  (GRANT_VALID),
    .GRANT_ID     (GRANT_ID),
    .BEAT_CNT     (BEAT_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to 1 ns after the next rising edge; inputs are driven there.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_data(input int idx, input logic [c_LEN-1:0] v);
    REQ_DATA[idx*c_LEN +: c_LEN] = v;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gv"},    32'(GRANT_VALID),  32'd0);
    check({tag, "_gid"},   32'(GRANT_ID),     32'd0);
    check({tag, "_bcnt"},  32'(BEAT_CNT),     32'd0);
    check({tag, "_ready"}, 32'(REQ_READY),    32'd0);
    check({tag, "_wr"},    32'(FIFO_WR),      32'd0);
    check({tag, "_data"},  32'(FIFO_DATA_WR), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESETN    = 1'b1;
    REQ_VALID = '0;
    REQ_DATA  = '0;
    REQ_LAST  = '0;
    FIFO_FULL = 1'b0;
    #2;
    RESETN = 1'b0;
    #1;
    check_reset_outputs("rst0");
    cyc();
    cyc();
    RESETN = 1'b1;

    // ---- Single producer 2, three beats, LAST on the third ----------------
    cyc();
    REQ_VALID = 4'b0100;
    set_data(2, 16'h00A1);
    #1;
    check("t1_idle_gv",    32'(GRANT_VALID), 32'd0);
    check("t1_idle_ready", 32'(REQ_READY),   32'd0);
    check("t1_idle_wr",    32'(FIFO_WR),     32'd0);
    cyc();
    #1;
    check("t1_b1_gv",    32'(GRANT_VALID),  32'd1);
    check("t1_b1_gid",   32'(GRANT_ID),     32'd2);
    check("t1_b1_ready", 32'(REQ_READY),    32'b0100);
    check("t1_b1_wr",    32'(FIFO_WR),      32'd1);
    check("t1_b1_data",  32'(FIFO_DATA_WR), 32'h00A1);
    check("t1_b1_bcnt",  32'(BEAT_CNT),     32'd0);
    cyc();
    set_data(2, 16'h00A2);
    #1;
    check("t1_b2_data", 32'(FIFO_DATA_WR), 32'h00A2);
    check("t1_b2_bcnt", 32'(BEAT_CNT),     32'd1);
    cyc();
    set_data(2, 16'h00A3);
    REQ_LAST = 4'b0100;
    #1;
    check("t1_b3_wr",   32'(FIFO_WR),      32'd1);
    check("t1_b3_data", 32'(FIFO_DATA_WR), 32'h00A3);
    check("t1_b3_bcnt", 32'(BEAT_CNT),     32'd2);
    cyc();
    REQ_VALID = '0;
    REQ_LAST  = '0;
    #1;
    check("t1_end_gv",   32'(GRANT_VALID), 32'd0);
    check("t1_end_wr",   32'(FIFO_WR),     32'd0);
    check("t1_end_bcnt", 32'(BEAT_CNT),    32'd3);

    // ---- Producers 0 and 3: last_id=2 picks 3; 3 forfeits, wrap to 0 -------
    cyc();
    REQ_VALID = 4'b1001;
    set_data(0, 16'h00B0);
    set_data(3, 16'h00B3);
    cyc();
    #1;
    check("t4_gid3",  32'(GRANT_ID),     32'd3);
    check("t4_data3", 32'(FIFO_DATA_WR), 32'h00B3);
    cyc();
    REQ_VALID = 4'b0001;
    #1;
    check("t4_drop_gv",    32'(GRANT_VALID), 32'd1);
    check("t4_drop_gid",   32'(GRANT_ID),    32'd3);
    check("t4_drop_wr",    32'(FIFO_WR),     32'd0);
    check("t4_drop_ready", 32'(REQ_READY),   32'b1000);
    check("t4_drop_bcnt",  32'(BEAT_CNT),    32'd1);
    cyc();
    #1;
    check("t4_bubble_gv", 32'(GRANT_VALID), 32'd0);
    cyc();
    #1;
    check("t4_wrap_gv",   32'(GRANT_VALID),  32'd1);
    check("t4_wrap_gid",  32'(GRANT_ID),     32'd0);
    check("t4_wrap_data", 32'(FIFO_DATA_WR), 32'h00B0);
    cyc();
    REQ_VALID = '0;
    cyc();
    cyc();

    // ---- Async reset, then all four producers continuously valid ----------
    #2;
    RESETN = 1'b0;
    #1;
    check_reset_outputs("rst1");
    cyc();
    REQ_VALID = 4'b1111;
    for (int i = 0; i < c_NR; i++) set_data(i, 16'(16'hC000 + i));
    RESETN = 1'b1;
    cyc();
    begin
      int order [5] = '{0, 1, 2, 3, 0};
      for (int g = 0; g < 5; g++) begin
        for (int b = 0; b < c_MB; b++) begin
          #1;
          check($sformatf("t2_g%0d_b%0d_gid", g, b),  32'(GRANT_ID),     32'(order[g]));
          check($sformatf("t2_g%0d_b%0d_wr", g, b),   32'(FIFO_WR),      32'd1);
          check($sformatf("t2_g%0d_b%0d_data", g, b), 32'(FIFO_DATA_WR), 32'h0000C000 + 32'(order[g]));
          check($sformatf("t2_g%0d_b%0d_bcnt", g, b), 32'(BEAT_CNT),     32'(b));
          cyc();
        end
        if (g == 4) REQ_VALID = '0;
        #1;
        check($sformatf("t2_g%0d_bubble_gv", g),   32'(GRANT_VALID), 32'd0);
        check($sformatf("t2_g%0d_bubble_bcnt", g), 32'(BEAT_CNT),    32'd4);
        cyc();
      end
    end

    // ---- FIFO full for 5 cycles mid-burst on producer 1 -------------------
    #2;
    RESETN = 1'b0;
    #1;
    cyc();
    REQ_VALID = 4'b0010;
    set_data(1, 16'h00D1);
    RESETN = 1'b1;
    cyc();
    #1;
    check("t3_b1_gid",  32'(GRANT_ID),     32'd1);
    check("t3_b1_data", 32'(FIFO_DATA_WR), 32'h00D1);
    for (int f = 0; f < 5; f++) begin
      cyc();
      FIFO_FULL = 1'b1;
      REQ_VALID = (f == 2 || f == 3) ? 4'b0000 : 4'b0010;
      set_data(1, 16'h00D2);
      #1;
      check($sformatf("t3_full%0d_gv", f),    32'(GRANT_VALID),  32'd1);
      check($sformatf("t3_full%0d_gid", f),   32'(GRANT_ID),     32'd1);
      check($sformatf("t3_full%0d_wr", f),    32'(FIFO_WR),      32'd0);
      check($sformatf("t3_full%0d_ready", f), 32'(REQ_READY),    32'd0);
      check($sformatf("t3_full%0d_data", f),  32'(FIFO_DATA_WR), 32'd0);
      check($sformatf("t3_full%0d_bcnt", f),  32'(BEAT_CNT),     32'd1);
    end
    cyc();
    FIFO_FULL = 1'b0;
    REQ_VALID = 4'b0010;
    #1;
    check("t3_b2_wr",    32'(FIFO_WR),      32'd1);
    check("t3_b2_ready", 32'(REQ_READY),    32'b0010);
    check("t3_b2_data",  32'(FIFO_DATA_WR), 32'h00D2);
    check("t3_b2_bcnt",  32'(BEAT_CNT),     32'd1);
    cyc();
    set_data(1, 16'h00D3);
    #1;
    check("t3_b3_data", 32'(FIFO_DATA_WR), 32'h00D3);
    check("t3_b3_bcnt", 32'(BEAT_CNT),     32'd2);
    cyc();
    set_data(1, 16'h00D4);
    #1;
    check("t3_b4_data", 32'(FIFO_DATA_WR), 32'h00D4);
    check("t3_b4_bcnt", 32'(BEAT_CNT),     32'd3);
    cyc();
    REQ_VALID = '0;
    #1;
    check("t3_end_gv",   32'(GRANT_VALID), 32'd0);
    check("t3_end_bcnt", 32'(BEAT_CNT),    32'd4);

    // ---- Async reset during beat 2 of a burst on producer 2 ---------------
    cyc();
    REQ_VALID = 4'b0110;
    set_data(1, 16'h00E1);
    set_data(2, 16'h00E2);
    cyc();
    #1;
    check("t5_gid2",  32'(GRANT_ID),     32'd2);
    check("t5_data2", 32'(FIFO_DATA_WR), 32'h00E2);
    cyc();
    #1;
    check("t5_b2_wr",   32'(FIFO_WR),  32'd1);
    check("t5_b2_bcnt", 32'(BEAT_CNT), 32'd1);
    #2;
    RESETN = 1'b0;
    #1;
    check_reset_outputs("t5_rst");
    cyc();
    check("t5_rst_hold_gv", 32'(GRANT_VALID), 32'd0);
    RESETN = 1'b1;
    cyc();
    #1;
    check("t5_after_gv",    32'(GRANT_VALID),  32'd1);
    check("t5_after_gid",   32'(GRANT_ID),     32'd1);
    check("t5_after_data",  32'(FIFO_DATA_WR), 32'h00E1);
    check("t5_after_ready", 32'(REQ_READY),    32'b0010);
    REQ_VALID = '0;
    cyc();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
